iob_fp_div_seq: RTL
===================

# iob_fp_div_seq

Issue/collect sequencer that sits directly upstream of the iterative floating-point divider, `iob_fp_div`. It accepts division requests on a valid/ready stream and issues one `start` pulse per request. It holds the operands stable for the whole divider run, then captures the result with its request tag. The result goes out on a valid/ready stream, with a watchdog that converts a missing `done` into a canonical-NaN result flagged as a timeout.

## Interface
- `DATA_W`, 32: floating-point word width.
- `EXP_W`, 8: exponent width; used for the canonical NaN.
- `TAG_W`, 4: request tag width.
- `TIMEOUT`, 64: maximum WAIT cycles before giving up; must be ≥ 2.
- `clk_i` in 1: clock. Single clock domain.
- `arst_n_i` in 1: reset, asynchronous, active-low.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: request ready.
- `in_op_a_i` in DATA_W: dividend.
- `in_op_b_i` in DATA_W: divisor.
- `in_tag_i` in TAG_W: request tag.
- `div_start_o` out 1: divider start pulse; exactly 1 cycle wide.
- `div_op_a_o` out DATA_W: registered operand A to the divider.
- `div_op_b_o` out DATA_W: registered operand B to the divider.
- `div_done_i` in 1: divider done.
- `div_res_i` in DATA_W: divider result; valid while `div_done_i`=1.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: result ready.
- `out_res_o` out DATA_W: result.
- `out_tag_o` out TAG_W: tag of the request.
- `out_timeout_o` out 1: result was produced by the watchdog.
- `busy_o` out 1: state is not IDLE.

## Operation
- The FSM has four states: IDLE, START, WAIT, RESP.
- **IDLE**
  - `in_ready_o`=1.
  - On `in_valid_i`: register `in_op_a_i` into `div_op_a_o`, `in_op_b_i` into `div_op_b_o`, and the tag; go to START.
- **START**
  - `div_start_o`=1; clear the watchdog counter; go to WAIT.
  - `div_done_i` is ignored in this state.
- **WAIT**
  - The counter increments every cycle from 0.
  - If `div_done_i`=1: capture `div_res_i` into `out_res_o`, set `out_timeout_o`=0, go to RESP.
  - Else, if counter == TIMEOUT-1: set `out_res_o`={1'b0, {EXP_W{1}}, 1'b1, zeros} (0x7FC00000 at default parameters), set `out_timeout_o`=1, go to RESP.
  - `done` has priority over timeout in the same cycle.
- **RESP**
  - `out_valid_o`=1; `in_ready_o`=`out_ready_i`.
  - `out_ready_i`=1 with `in_valid_i`=1: complete the output handshake and accept the new request in the same cycle; go to START.
  - `out_ready_i`=1 with `in_valid_i`=0: go to IDLE.
  - `out_ready_i`=0: hold all outputs.
- `div_op_a_o` and `div_op_b_o` change only on request acceptance. They are stable from START until the next acceptance, because the divider samples operands combinationally across its run.
- `div_done_i` outside WAIT is ignored and causes no state change, including a late `done` after a timeout.
- `out_tag_o` is the registered tag of the request being answered.
- `out_res_o`, `out_tag_o` and `out_timeout_o` are stable while `out_valid_o`=1 and `out_ready_i`=0.
- The counter width is $clog2(TIMEOUT). It is never compared beyond TIMEOUT-1, so it cannot wrap.

## Timing
- Reset (`arst_n_i`=0, any time, including mid-WAIT): state IDLE immediately (asynchronous).
- All outputs are 0 during reset except `in_ready_o`, which is 1 (IDLE). This covers `div_start_o`, `div_op_*`, `out_*`, `busy_o` and the counter.
- Reset deassertion does not issue a start.
- Request accepted at edge t → `div_start_o`=1 during cycle t+1 → WAIT from t+2.
- `div_done_i` sampled at edge d in WAIT → `out_valid_o`=1 from d+1.
- Timeout with no `done`: `out_valid_o` rises after exactly TIMEOUT WAIT cycles, i.e. accept + TIMEOUT + 2 cycles.
- Minimum issue interval with `out_ready_i` tied to 1: divider latency + 3 cycles.
- At most one request is outstanding at a time. `in_ready_o` is 0 in START and WAIT.

## Test plan
- Single request A=0x40C00000 (6.0), B=0x40000000 (2.0), tag=5; divider model asserts `done` with 0x40400000 → exactly one `div_start_o` pulse, `out_res_o`=0x40400000, `out_tag_o`=5, `out_timeout_o`=0.
- Back-to-back requests with `out_ready_i`=0 for 10 cycles after the first result → first result held stable; `in_ready_o`=0 throughout; second request accepted on the same edge as the output handshake; `div_op_a_o` and `div_op_b_o` never change during WAIT.
- Divider model never asserts `done` → after TIMEOUT=64 WAIT cycles `out_res_o`=0x7FC00000 and `out_timeout_o`=1; a late `done` in IDLE or RESP is ignored.
- `done` asserted in the same cycle the counter reaches 63 → divider result delivered, `out_timeout_o`=0.
- `arst_n_i` pulsed low mid-WAIT → all outputs take reset values immediately; no `div_start_o` after release; next request processed normally.
- `done` pulse during the START cycle, then a real `done` 20 cycles later → only the later result is captured.

Source files
------------

// File: rtl/iob_fp_div_seq.sv
// Issue/collect sequencer in front of the iterative FP divider.
// Holds operands for the run, collects result+tag, watchdog to qNaN.
module iob_fp_div_seq #(
  parameter int DATA_W  = 32,
  parameter int EXP_W   = 8,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_op_a_i,
  input  logic [DATA_W-1:0] in_op_b_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              div_start_o,
  output logic [DATA_W-1:0] div_op_a_o,
  output logic [DATA_W-1:0] div_op_b_o,
  input  logic              div_done_i,
  input  logic [DATA_W-1:0] div_res_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_res_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic              out_timeout_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] QNAN = {
    1'b0, {EXP_W{1'b1}}, 1'b1,
    {(DATA_W - EXP_W - 2){1'b0}}
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             tmo_hit;

  assign accept  = in_valid_i & in_ready_o;
  assign tmo_hit = (cnt_q == CNT_MAX);
  assign busy_o  = (state_q != S_IDLE);

  // State register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    div_start_o = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = S_START;
      end
      S_START: begin
        div_start_o = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (div_done_i || tmo_hit)
          state_d = S_RESP;
      end
      S_RESP: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        if (out_ready_i)
          state_d = in_valid_i ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand/tag capture, watchdog and result capture
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      div_op_a_o    <= '0;
      div_op_b_o    <= '0;
      out_tag_o     <= '0;
      out_res_o     <= '0;
      out_timeout_o <= 1'b0;
      cnt_q         <= '0;
    end else begin
      if (accept) begin
        div_op_a_o <= in_op_a_i;
        div_op_b_o <= in_op_b_i;
        out_tag_o  <= in_tag_i;
      end
      if (state_q == S_START) begin
        cnt_q <= '0;
      end
      if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (div_done_i) begin
          out_res_o     <= div_res_i;
          out_timeout_o <= 1'b0;
        end else if (tmo_hit) begin
          out_res_o     <= QNAN;
          out_timeout_o <= 1'b1;
        end
      end
    end
  end

endmodule
